// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector stage.
// Holds the serializer FSM state type and the default word width that the
// serializer and the detector-side benches both build against.
package seq_det_pkg;

  // Default data bits per word for the serializer feeding the detector.
  localparam int SEQ_DET_WIDTH = 8;

  // Serializer FSM states. SER_PARITY is only reachable when the parity
  // option is compiled in.
  typedef enum logic [1:0] {
    SER_IDLE   = 2'd0,
    SER_SHIFT  = 2'd1,
    SER_PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: hold register + shift register, streams
// WIDTH-bit words one bit per clk onto ser_bit with no bubble between words.
// Ports: clk/rst (async, active-high); in_data/in_valid/in_ready handshake
//   (in_ready = hold empty, registered only); ser_bit/ser_valid serial output;
//   word_done pulses with a word's last bit; busy = hold full or shifting.
// Config: define SER_PARITY_EN to append one even-parity bit per word
//   (word_done then moves to the parity bit).
// Latency: first bit 2 clk after the accept cycle when idle.
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = SEQ_DET_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ser_bit_q, ser_bit_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic last_data;  // final data bit is on ser_bit
  logic word_end;   // final bit of the word (data or parity) is on ser_bit
  logic load;
  logic accept;
  logic nxt_bit;

  always_comb begin
    last_data = (state_q == SER_SHIFT) && (bit_cnt_q == LAST_CNT);
`ifdef SER_PARITY_EN
    word_end  = (state_q == SER_PARITY);
`else
    word_end  = last_data;
`endif
    // Reload either into an idle shifter or straight behind the final bit,
    // which is what keeps queued words contiguous.
    load   = hold_full_q && ((state_q == SER_IDLE) || word_end);
    // Accept only depends on registered hold_full, so it can never coincide
    // with a load on the same edge.
    accept = in_valid && !hold_full_q;
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ser_bit_d   = 1'b0;
    nxt_bit     = 1'b0;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif

    // shreg keeps the bit currently on ser_bit at its head; each shift
    // exposes the next one, which is registered into ser_bit_q.
    if (MSB_FIRST) begin
      nxt_bit = shreg_q[WIDTH-2];
    end else begin
      nxt_bit = shreg_q[1];
    end

    case (state_q)
      SER_IDLE: begin
        state_d = SER_IDLE;
      end
      SER_SHIFT: begin
        if (MSB_FIRST) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
        if (bit_cnt_q == LAST_CNT) begin
`ifdef SER_PARITY_EN
          state_d   = SER_PARITY;
          ser_bit_d = par_q;
`else
          state_d   = SER_IDLE;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          ser_bit_d = nxt_bit;
        end
      end
      SER_PARITY: begin
        state_d = SER_IDLE;
      end
      default: begin
        state_d = SER_IDLE;
      end
    endcase

    // Load overrides the end-of-word transition above.
    if (load) begin
      state_d     = SER_SHIFT;
      shreg_d     = hold_q;
      bit_cnt_d   = '0;
      hold_full_d = 1'b0;
      ser_bit_d   = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
`ifdef SER_PARITY_EN
      par_d       = ^hold_q;
`endif
    end

    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SER_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_bit_q   <= 1'b0;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_bit_q   <= ser_bit_d;
`ifdef SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign in_ready  = !hold_full_q;
  assign ser_bit   = ser_bit_q;
  assign ser_valid = (state_q != SER_IDLE);
  assign word_done = word_end;
  assign busy      = hold_full_q | (state_q != SER_IDLE);

endmodule
